lfsr_sequence_checker: RTL



---
 rtl/lfsr_sequence_checker_if.sv | 13 +
 rtl/lfsr_sequence_checker.sv | 111 +++++++++++
 2 files changed

// File: rtl/lfsr_sequence_checker_if.sv
// Serial receive bus for the LFSR checker: qualified bit in, lock/error status out.
interface lfsr_sequence_checker_if;
  logic        en;
  logic        si;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;

  // Link side drives bits and observes status.
  modport master (output en, si, input locked, err, err_cnt);
  // Checker side consumes bits and reports status.
  modport slave  (input en, si, output locked, err, err_cnt);
endinterface

// File: rtl/lfsr_sequence_checker.sv
// Self-seeding checker for the x^8+x^6+x^5+x^4+1 Fibonacci LFSR stream.
// SEED loads 8 received bits as the local state; CHECK free-runs the local
// LFSR and compares each qualified bit, dropping lock after ERR_LIMIT
// mismatches inside one WINDOW-bit window.
module lfsr_sequence_checker #(
  parameter int WINDOW    = 64,
  parameter int ERR_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    syncInt,
  lfsr_sequence_checker_if.slave  bus
);

  typedef enum logic {SEED = 1'b0, CHECK = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  s_q, s_d;
  logic [2:0]  fill_q, fill_d;
  logic [7:0]  win_cnt_q, win_cnt_d;   // WINDOW <= 256, so 0..255 fits
  logic [8:0]  win_err_q, win_err_d;   // ERR_LIMIT may reach 256
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        fb;
  logic        mismatch;
  logic [7:0]  seed_s;
  logic [8:0]  win_err_inc;

  assign fb          = s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3];
  assign mismatch    = bus.si ^ fb;
  assign seed_s      = {s_q[6:0], bus.si};
  assign win_err_inc = win_err_q + 9'd1;

  // Next-state: seeding, prediction/compare, window bookkeeping.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    fill_d    = fill_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (syncInt) begin
      // Re-hunt; any bit presented this cycle is dropped.
      state_d   = SEED;
      s_d       = 8'h00;
      fill_d    = 3'd0;
      win_cnt_d = 8'd0;
      win_err_d = 9'd0;
    end else if (bus.en) begin
      case (state_q)
        SEED: begin
          s_d    = seed_s;
          fill_d = fill_q + 3'd1;  // wraps to 0 on the 8th bit
          // All-zero is the LFSR lockup state: keep hunting.
          if (fill_q == 3'd7 && seed_s != 8'h00) state_d = CHECK;
        end
        CHECK: begin
          // Shift in the prediction so one bad bit gives one error.
          s_d = {s_q[6:0], fb};
          if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          if (mismatch && win_err_inc == 9'(ERR_LIMIT)) begin
            // Loss of lock outranks the window wrap.
            state_d   = SEED;
            s_d       = 8'h00;
            fill_d    = 3'd0;
            win_cnt_d = 8'd0;
            win_err_d = 9'd0;
          end else if (win_cnt_q == 8'(WINDOW - 1)) begin
            win_cnt_d = 8'd0;
            win_err_d = 9'd0;
          end else begin
            win_cnt_d = win_cnt_q + 8'd1;
            if (mismatch) win_err_d = win_err_inc;
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEED;
      s_q       <= 8'h00;
      fill_q    <= 3'd0;
      win_cnt_q <= 8'd0;
      win_err_q <= 9'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      fill_q    <= fill_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.locked  = (state_q == CHECK);
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule
